// File: rtl/alu_sched_pkg.sv
// Shared definitions for alu_sched: SPARC ALU opcodes, icc bit positions,
// scheduler states and opcode decode helpers.
package alu_sched_pkg;

  localparam logic [5:0] ADD     = 6'b000000;
  localparam logic [5:0] AND     = 6'b000001;
  localparam logic [5:0] OR      = 6'b000010;
  localparam logic [5:0] XOR     = 6'b000011;
  localparam logic [5:0] SUB     = 6'b000100;
  localparam logic [5:0] ANDN    = 6'b000101;
  localparam logic [5:0] ORN     = 6'b000110;
  localparam logic [5:0] XNOR    = 6'b000111;
  localparam logic [5:0] ADDX    = 6'b001000;
  localparam logic [5:0] SUBX    = 6'b001100;
  localparam logic [5:0] ADDCC   = 6'b010000;
  localparam logic [5:0] ANDCC   = 6'b010001;
  localparam logic [5:0] ORCC    = 6'b010010;
  localparam logic [5:0] XORCC   = 6'b010011;
  localparam logic [5:0] SUBCC   = 6'b010100;
  localparam logic [5:0] ANDNCC  = 6'b010101;
  localparam logic [5:0] ORNCC   = 6'b010110;
  localparam logic [5:0] XNORCC  = 6'b010111;
  localparam logic [5:0] ADDXCC  = 6'b011000;
  localparam logic [5:0] SUBXCC  = 6'b011100;
  localparam logic [5:0] SLL     = 6'b100101;
  localparam logic [5:0] SRL     = 6'b100110;
  localparam logic [5:0] SRA     = 6'b100111;

  localparam int ICC_N = 3;
  localparam int ICC_Z = 2;
  localparam int ICC_V = 1;
  localparam int ICC_C = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    ICC_KEEP  = 2'd0,
    ICC_ARITH = 2'd1,
    ICC_LOGIC = 2'd2
  } icc_cls_t;

  function automatic logic op_legal(input logic [5:0] op);
    logic ok;
    if (op[5] == 1'b0) begin
      ok = (op[3] == 1'b0) || (op[1:0] == 2'b00);
    end else begin
      ok = (op == SLL) || (op == SRL) || (op == SRA);
    end
    return ok;
  endfunction

  // Flag-setting ops live at op[5:4]=01; the low bits split arith from logic.
  function automatic icc_cls_t icc_class(input logic [5:0] op);
    icc_cls_t cls;
    if (op[5:4] == 2'b01) begin
      if (op[1:0] == 2'b00) begin
        cls = ICC_ARITH;
      end else begin
        cls = ICC_LOGIC;
      end
    end else begin
      cls = ICC_KEEP;
    end
    return cls;
  endfunction

endpackage

// File: rtl/alu_sched_rr_arbiter.sv
// Two-way round-robin arbiter; the priority pointer moves only when a grant
// is actually accepted.
module alu_rr_arbiter (
  input  logic clk,
  input  logic reset,
  input  logic req0,
  input  logic req1,
  input  logic accept,
  output logic gnt0,
  output logic gnt1
);

  logic prio_r;  // 0: req0 wins a tie, 1: req1 wins a tie

  always_comb begin
    if (req0 && req1) begin
      gnt0 = ~prio_r;
      gnt1 = prio_r;
    end else begin
      gnt0 = req0;
      gnt1 = req1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prio_r <= 1'b0;
    end else if (accept) begin
      prio_r <= gnt0;
    end else begin
      prio_r <= prio_r;
    end
  end

endmodule

// File: rtl/alu_sched.sv
// Two-requester ALU scheduler owning the SPARC icc flags.
// Optional ALU_SCHED_ICC_WR_EN adds a direct icc write port (WRPSR path).
module alu_sched
  import alu_sched_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [5:0]  req0_op,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [5:0]  req1_op,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic        resp_id,
  output logic [31:0] resp_result,
  output logic        resp_err,
`ifdef ALU_SCHED_ICC_WR_EN
  input  logic        icc_wr_en,
  input  logic [3:0]  icc_wr_data,
`endif
  output logic [3:0]  icc,
  output logic [5:0]  alu_opcode,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic        alu_carry,
  input  logic [31:0] alu_result,
  input  logic        alu_n,
  input  logic        alu_z,
  input  logic        alu_c,
  input  logic        alu_v
);

  state_t      state_r;
  logic        id_r;
  logic        err_r;
  logic        gnt0, gnt1;
  logic        can_accept, accept;
  logic [5:0]  sel_op;
  logic [31:0] sel_a, sel_b;

  alu_rr_arbiter u_arb (
    .clk    (clk),
    .reset  (reset),
    .req0   (req0_valid),
    .req1   (req1_valid),
    .accept (accept),
    .gnt0   (gnt0),
    .gnt1   (gnt1)
  );

  assign can_accept = (state_r == ST_IDLE) || ((state_r == ST_DONE) && resp_ready);
  assign req0_ready = can_accept & gnt0;
  assign req1_ready = can_accept & gnt1;
  assign accept     = (req0_valid & req0_ready) | (req1_valid & req1_ready);
  assign alu_carry  = icc[ICC_C];

  always_comb begin
    if (gnt1) begin
      sel_op = req1_op;
      sel_a  = req1_a;
      sel_b  = req1_b;
    end else begin
      sel_op = req0_op;
      sel_a  = req0_a;
      sel_b  = req0_b;
    end
  end

  // Sequencer: accept, one EXEC cycle on the external ALU, then hold the response.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      id_r        <= 1'b0;
      err_r       <= 1'b0;
      icc         <= 4'b0000;
      resp_valid  <= 1'b0;
      resp_id     <= 1'b0;
      resp_result <= 32'd0;
      resp_err    <= 1'b0;
      alu_opcode  <= 6'd0;
      alu_a       <= 32'd0;
      alu_b       <= 32'd0;
    end else begin
      // Illegal ops leave the ALU operands untouched so nothing is issued.
      if (accept) begin
        id_r  <= gnt1;
        err_r <= ~op_legal(sel_op);
        if (op_legal(sel_op)) begin
          alu_opcode <= sel_op;
          alu_a      <= sel_a;
          alu_b      <= sel_b;
        end
      end

      case (state_r)
        ST_IDLE: begin
          state_r <= accept ? ST_EXEC : ST_IDLE;
        end
        ST_EXEC: begin
          resp_valid  <= 1'b1;
          resp_id     <= id_r;
          resp_err    <= err_r;
          resp_result <= err_r ? 32'd0 : alu_result;
          if (!err_r) begin
            case (icc_class(alu_opcode))
              ICC_ARITH: icc <= {alu_n, alu_z, alu_v, alu_c};
              ICC_LOGIC: icc <= {alu_n, alu_z, 2'b00};
              default:   icc <= icc;
            endcase
          end
          state_r <= ST_DONE;
        end
        ST_DONE: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state_r    <= accept ? ST_EXEC : ST_IDLE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase

`ifdef ALU_SCHED_ICC_WR_EN
      // Placed last so an external write overrides a same-cycle ALU update.
      if (icc_wr_en) begin
        icc <= icc_wr_data;
      end
`endif
    end
  end

endmodule

// File: tb/tb_alu_sched.sv
// Scoreboard bench for alu_sched with a behavioural SPARC ALU alongside it.
// Define ALU_SCHED_ICC_WR_EN to also exercise the direct icc write port.
module tb_alu_sched;
  import alu_sched_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [5:0]  req0_op, req1_op;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        resp_valid, resp_ready, resp_id, resp_err;
  logic [31:0] resp_result;
  logic [3:0]  icc;
  logic [5:0]  alu_opcode;
  logic [31:0] alu_a, alu_b, alu_result;
  logic        alu_carry, alu_n, alu_z, alu_c, alu_v;
`ifdef ALU_SCHED_ICC_WR_EN
  logic        icc_wr_en;
  logic [3:0]  icc_wr_data;
`endif

  typedef struct {
    logic        id;
    logic [31:0] res;
    logic        err;
    logic [3:0]  icc;
  } exp_t;

  exp_t sb[$];
  logic grants[$];
  exp_t mon_e;
  logic [3:0] exp_icc;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   last_cyc = -1;
  logic tp_phase = 1'b0;
  logic icc_chk = 1'b1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_sched dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_result(resp_result), .resp_err(resp_err),
`ifdef ALU_SCHED_ICC_WR_EN
    .icc_wr_en(icc_wr_en), .icc_wr_data(icc_wr_data),
`endif
    .icc(icc), .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
    .alu_carry(alu_carry), .alu_result(alu_result),
    .alu_n(alu_n), .alu_z(alu_z), .alu_c(alu_c), .alu_v(alu_v)
  );

  // Returns {n, z, v, c, result[31:0]}.
  function automatic logic [35:0] alu_ref(input logic [5:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic cin);
    logic [32:0] w;
    logic [31:0] r;
    logic c, v;
    w = 33'd0; r = 32'd0; c = 1'b0; v = 1'b0;
    case (op)
      ADD, ADDCC, ADDX, ADDXCC: begin
        w = {1'b0, a} + {1'b0, b} + ((op[3] == 1'b1) ? {32'd0, cin} : 33'd0);
        r = w[31:0]; c = w[32];
        v = (a[31] == b[31]) && (r[31] != a[31]);
      end
      SUB, SUBCC, SUBX, SUBXCC: begin
        w = {1'b0, a} - {1'b0, b} - ((op[3] == 1'b1) ? {32'd0, cin} : 33'd0);
        r = w[31:0]; c = w[32];
        v = (a[31] != b[31]) && (r[31] != a[31]);
      end
      AND, ANDCC:   r = a & b;
      OR, ORCC:     r = a | b;
      XOR, XORCC:   r = a ^ b;
      ANDN, ANDNCC: r = a & ~b;
      ORN, ORNCC:   r = a | ~b;
      XNOR, XNORCC: r = ~(a ^ b);
      SLL:          r = a << b[4:0];
      SRL:          r = a >> b[4:0];
      SRA:          r = 32'($signed(a) >>> b[4:0]);
      default:      r = 32'd0;
    endcase
    return {r[31], (r == 32'd0), v, c, r};
  endfunction

  always_comb {alu_n, alu_z, alu_v, alu_c, alu_result} = alu_ref(alu_opcode, alu_a, alu_b, alu_carry);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push(input logic id, input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic [35:0] r;
    logic legal;
    legal = op[5] ? (op == 6'b100101 || op == 6'b100110 || op == 6'b100111)
                  : (op[3] == 1'b0 || op[1:0] == 2'b00);
    e.id = id;
    if (!legal) begin
      e.res = 32'd0;
      e.err = 1'b1;
    end else begin
      r = alu_ref(op, a, b, exp_icc[0]);
      e.res = r[31:0];
      e.err = 1'b0;
      if (op[5:4] == 2'b01) exp_icc = (op[1:0] == 2'b00) ? r[35:32] : {r[35:34], 2'b00};
    end
    e.icc = exp_icc;
    sb.push_back(e);
    if (tp_phase) grants.push_back(id);
  endtask

  // Response side pops the scoreboard; request side pushes on every accept.
  always @(negedge clk) begin
    if (!reset) begin
      if (resp_valid && resp_ready) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", 32'd1, 32'd0);
        end else begin
          mon_e = sb.pop_front();
          chk("resp_id", {31'd0, resp_id}, {31'd0, mon_e.id});
          chk("resp_result", resp_result, mon_e.res);
          chk("resp_err", {31'd0, resp_err}, {31'd0, mon_e.err});
          if (icc_chk) chk("resp_icc", {28'd0, icc}, {28'd0, mon_e.icc});
        end
        if (tp_phase) begin
          if (last_cyc >= 0) chk("tp_gap", cyc - last_cyc, 32'd2);
          last_cyc = cyc;
        end
      end
      if (req0_valid && req0_ready) push(1'b0, req0_op, req0_a, req0_b);
      else if (req1_valid && req1_ready) push(1'b1, req1_op, req1_a, req1_b);
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Call at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic send(input int port, input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    int n;
    if (port == 0) begin
      req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
    end else begin
      req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!((port == 0) ? req0_ready : req1_ready) && n < 200);
    if (n >= 200) chk("send_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    if (port == 0) req0_valid = 1'b0;
    else req1_valid = 1'b0;
  endtask

  task automatic wait_resp();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!resp_valid && n < 50);
    if (n >= 50) chk("resp_timeout", 32'd0, 32'd1);
  endtask

  logic [5:0] tbl [12] = '{ADD, ADDCC, ADDXCC, SUBCC, SUBXCC, ANDCC,
                           ORNCC, XNORCC, XOR, SLL, SRA, SUBX};

  initial begin
    reset = 1'b1; resp_ready = 1'b1; exp_icc = 4'b0000;
    req0_valid = 1'b0; req0_op = 6'd0; req0_a = 32'd0; req0_b = 32'd0;
    req1_valid = 1'b0; req1_op = 6'd0; req1_a = 32'd0; req1_b = 32'd0;
`ifdef ALU_SCHED_ICC_WR_EN
    icc_wr_en = 1'b0; icc_wr_data = 4'b0000;
`endif
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_resp_result", resp_result, 32'd0);
    chk("rst_resp_id", {31'd0, resp_id}, 32'd0);
    chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
    chk("rst_icc", {28'd0, icc}, 32'd0);
    chk("rst_alu_op", {26'd0, alu_opcode}, 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_carry", {31'd0, alu_carry}, 32'd0);

    // ADDCC with carry-out and zero result; latency T+2
    step();
    send(0, ADDCC, 32'hFFFF_FFFF, 32'd1);
    @(negedge clk);
    chk("lat_exec_valid", {31'd0, resp_valid}, 32'd0);
    @(negedge clk);
    chk("lat_resp_valid", {31'd0, resp_valid}, 32'd1);
    chk("addcc_result", resp_result, 32'd0);
    chk("addcc_id", {31'd0, resp_id}, 32'd0);
    chk("addcc_icc", {28'd0, icc}, 32'h5);

    step();
    send(0, ADDX, 32'd0, 32'd0);
    wait_resp();
    chk("addx_c1", resp_result, 32'd1);

    step();
    send(1, SUBCC, 32'h8000_0000, 32'd1);
    wait_resp();
    chk("subcc_result", resp_result, 32'h7FFF_FFFF);
    chk("subcc_icc", {28'd0, icc}, 32'h2);
    chk("subcc_id", {31'd0, resp_id}, 32'd1);
    step();
    send(0, ADDX, 32'd0, 32'd0);
    wait_resp();
    chk("addx_c0", resp_result, 32'd0);

    step();
    send(0, ADDCC, 32'h8000_0000, 32'h8000_0000);
    wait_resp();
    chk("vc_icc", {28'd0, icc}, 32'h7);
    step();
    send(0, ANDCC, 32'hF000_0000, 32'hF000_0000);
    wait_resp();
    chk("andcc_icc", {28'd0, icc}, 32'h8);
    step();
    send(0, SLL, 32'd1, 32'd4);
    wait_resp();
    chk("sll_result", resp_result, 32'h10);
    chk("sll_icc", {28'd0, icc}, 32'h8);

    // Illegal opcode held with resp_ready low
    step();
    resp_ready = 1'b0;
    send(1, 6'b001001, 32'd5, 32'd6);
    wait_resp();
    for (int i = 0; i < 3; i++) begin
      chk("ill_valid", {31'd0, resp_valid}, 32'd1);
      chk("ill_err", {31'd0, resp_err}, 32'd1);
      chk("ill_result", resp_result, 32'd0);
      chk("ill_icc", {28'd0, icc}, 32'h8);
      @(negedge clk);
    end
    @(posedge clk); #1 resp_ready = 1'b1;
    @(negedge clk);

    // Both ports busy: alternating grants, one response every 2 cycles
    step();
    tp_phase = 1'b1;
    fork
      begin
        for (int i = 0; i < 4; i++)
          send(0, tbl[$urandom_range(0, 11)], $urandom, $urandom);
      end
      begin
        for (int j = 0; j < 4; j++)
          send(1, tbl[$urandom_range(0, 11)], $urandom, $urandom);
      end
    join
    for (int k = 0; k < 20 && sb.size() != 0; k++) @(negedge clk);
    tp_phase = 1'b0;
    chk("tp_grant_count", grants.size(), 32'd8);
    for (int k = 0; k < grants.size(); k++)
      chk("tp_grant_order", {31'd0, grants[k]}, k % 2);

    // Reset while an op is in EXEC
    step();
    send(0, ADDCC, 32'hFFFF_FFFF, 32'd1);
    wait_resp();
    step();
    send(0, ADDCC, 32'd1, 32'd1);
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    if (sb.size() > 0) sb.delete(sb.size() - 1);
    exp_icc = 4'b0000;
    @(negedge clk);
    chk("rstx_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rstx_icc", {28'd0, icc}, 32'd0);
    step();
    send(0, ADDX, 32'd0, 32'd0);
    wait_resp();
    chk("rstx_addx", resp_result, 32'd0);

`ifdef ALU_SCHED_ICC_WR_EN
    step();
    icc_chk = 1'b0;
    send(0, ADDCC, 32'd0, 32'd0);
    icc_wr_en = 1'b1; icc_wr_data = 4'b0001;
    @(posedge clk); #1 icc_wr_en = 1'b0;
    @(negedge clk);
    chk("wr_icc", {28'd0, icc}, 32'h1);
    exp_icc = 4'b0001;
    step();
    icc_chk = 1'b1;
    send(0, ADDX, 32'd0, 32'd0);
    wait_resp();
    chk("wr_addx", resp_result, 32'd1);
`endif

    repeat (4) @(negedge clk);
    chk("sb_empty", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_sched.md
# alu_sched

Two-requester scheduler for the 32-bit SPARC integer ALU. Arbitrates between an integer-unit port (req0) and an address/auxiliary port (req1) with round-robin fairness. Sequences one ALU operation at a time and owns the integer condition codes (icc = N,Z,V,C), feeding carry back to the ALU. Sits between decode/issue and the ALU; the ALU itself is instantiated alongside it, not inside it.

## Interface
- No parameters; data width fixed at 32, opcode width fixed at 6.
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- req0_valid / req1_valid  in  1  request present
- req0_ready / req1_ready  out  1  request accepted this cycle when valid & ready
- req0_op / req1_op  in  6  ALU opcode
- req0_a, req0_b / req1_a, req1_b  in  32  operands
- resp_valid  out  1  response held until resp_ready
- resp_ready  in  1  consumer accepts response
- resp_id  out  1  0 = req0, 1 = req1
- resp_result  out  32  ALU result, or 0 on illegal opcode
- resp_err  out  1  illegal opcode
- icc  out  4  {N,Z,V,C}, architectural condition codes
- alu_opcode  out  6;  alu_a, alu_b  out  32;  alu_carry  out  1  = icc[0]
- alu_result  in  32;  alu_n, alu_z, alu_c, alu_v  in  1  combinational ALU outputs

## Operation
- FSM states: IDLE, EXEC, DONE.
- IDLE: grant via arbiter; on accept, register op/a/b/id → EXEC.
- EXEC: drive alu_* from registered operands; at cycle end, capture result, update icc, set resp_valid → DONE.
- DONE: hold response; on resp_ready → IDLE, or accept a new request in the same cycle → EXEC.
- req*_ready is 1 only in IDLE, or in DONE with resp_ready=1. It is given only to the granted requester.
- Arbitration: round-robin over a 1-bit last-grant pointer; the pointer updates only on accept. With one requester valid, that requester wins.
- Legal opcodes:
  - op[5]=0 with op[3]=0 or op[1:0]=00;
  - op[5]=1 only 100101, 100110, 100111.
- Illegal opcode: no ALU issue effect, resp_err=1, resp_result=0, icc unchanged.
- icc update, only for legal opcodes:
  - op[5:4]=01 and op[1:0]=00 (arith with S): icc ← {alu_n, alu_z, alu_v, alu_c}.
  - op[5:4]=01 and op[1:0]≠00 (logic with S): N,Z ← alu_n, alu_z; V,C ← 0.
  - All other opcodes, including shifts: icc unchanged.
- ADDX/SUBX operations use alu_carry = icc.C as it stood when the request was accepted. icc cannot change between accept and EXEC.

## Timing
- Reset values: state IDLE, icc 4'b0000, rr pointer favours req0, resp_valid 0, resp_result 0, resp_id 0, resp_err 0, alu_* outputs 0.
- Latency: accept at cycle T, EXEC at T+1, resp_valid=1 at T+2.
- Peak throughput: one operation every 2 cycles, with resp_ready held high.
- icc reflects the new value from T+2, the same cycle resp_valid rises.
- Back-to-back dependent flag ops see the updated C.
- resp_* stable while resp_valid & !resp_ready.
- Reset mid-operation: in-flight op discarded, no response, icc cleared.

## Configuration
- ALU_SCHED_ICC_WR_EN defined: adds ports icc_wr_en (in, 1) and icc_wr_data (in, 4), which write icc directly (WRPSR path).
  - Writes are accepted in any state.
  - If a write coincides with an EXEC-cycle icc update, the external write wins.
  - A write during IDLE/DONE is visible on alu_carry of the next accepted op.
- ALU_SCHED_ICC_WR_EN undefined: ports absent; icc changes only via ALU ops and reset.

## Structure
- Shared package alu_sched_pkg holds:
  - opcode localparams (ADD, ADDCC, ADDX, ADDXCC, SUB, SUBCC, SUBX, SUBXCC, AND … XNORCC, SLL, SRL, SRA);
  - icc bit indices ICC_N=3, ICC_Z=2, ICC_V=1, ICC_C=0;
  - state enum;
  - legal-opcode and icc-update-class decode functions.
- Sub-module alu_rr_arbiter: 2-way round-robin grant with pointer update on accept.

## Test plan
- Single ADDCC on req0: a=32'hFFFF_FFFF, b=1 → at T+2 resp_result=0, resp_id=0, icc=0101 (Z,C).
- SUBCC a=0x8000_0000, b=1 (from req1), then ADDX a=0, b=0 → result 0x7FFF_FFFF with icc V=1; ADDX result equals icc.C of the preceding op.
- Both requesters valid continuously, resp_ready=1 → grants alternate 0,1,0,1; one response every 2 cycles.
- ANDCC a=0xF000_0000, b=0xF000_0000 after an op set V=C=1 → icc=1000. Then SLL a=1, b=4 → result 0x10, icc still 1000.
- Illegal opcode 6'b001001, then resp_ready held low 3 cycles → resp_err=1, result 0, icc unchanged, response stable.
- Reset asserted during EXEC → next cycle resp_valid=0, icc=0000, state IDLE.
- With ALU_SCHED_ICC_WR_EN defined: icc_wr_en with icc_wr_data=0001 during the EXEC of an ADDCC producing Z → icc=0001.
